// File: rtl/line_pkg.sv
// line_pkg: shared widths, default parameters and the state encoding
// for the line point generator and the regression block that feeds it.
`default_nettype none

package line_pkg;

    localparam int DEF_FRAC_BITS = 10;
    localparam int DEF_Y_MAX     = 767;
    localparam int X_W           = 11;
    localparam int Y_W           = 10;
    localparam int ACC_W         = 40;
    localparam int A_W           = 18;
    localparam int B_W           = 25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/line_point_gen.sv
// line_point_gen: walks x from x_start to x_end and streams y = a + b*x
// (b fixed point), floored and clamped to the drawable rows, with valid/ready.
`default_nettype none

module line_point_gen
    import line_pkg::*;
#(
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int Y_MAX     = DEF_Y_MAX
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic signed [A_W-1:0] a_in,
    input  logic signed [B_W-1:0] b_in,
    input  logic        [X_W-1:0] x_start_in,
    input  logic        [X_W-1:0] x_end_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic        [X_W-1:0] x_out,
    output logic        [Y_W-1:0] y_out,
    output logic                  in_range_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  done_out
);

    localparam logic signed [ACC_W-1:0] Y_MAX_ACC = ACC_W'(Y_MAX);
    localparam logic        [Y_W-1:0]   Y_MAX_Y   = Y_W'(Y_MAX);

    state_t                   state, next_state;
    logic signed [A_W-1:0]    a_q;
    logic signed [B_W-1:0]    b_q;
    logic        [X_W-1:0]    xs_q, xe_q;
    logic signed [ACC_W-1:0]  acc;

    logic                     advance, last;
    logic signed [ACC_W-1:0]  a_ext, b_ext, xs_ext, acc_start;
    logic signed [ACC_W-1:0]  acc_nxt, raw_y;
    logic        [X_W-1:0]    x_nxt;
    logic        [Y_W-1:0]    y_nxt;
    logic                     inr_nxt, upd;

    assign advance   = (state == ST_RUN) && valid_out && ready_in;
    assign last      = (x_out == xe_q);
    assign a_ext     = {{(ACC_W-A_W){a_q[A_W-1]}}, a_q};
    assign b_ext     = {{(ACC_W-B_W){b_q[B_W-1]}}, b_q};
    assign xs_ext    = {{(ACC_W-X_W){1'b0}}, xs_q};
    assign acc_start = (a_ext <<< FRAC_BITS) + b_ext * xs_ext;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= ST_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (valid_in) next_state = (x_start_in > x_end_in) ? ST_DONE : ST_LOAD;
            ST_LOAD: next_state = ST_RUN;
            ST_RUN:  if (advance && last) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // The point register is loaded with the value it will present next, so
    // the clamp sits in front of the output flops rather than behind them.
    always_comb begin
        acc_nxt = acc;
        x_nxt   = x_out;
        upd     = 1'b0;
        if (state == ST_LOAD) begin
            acc_nxt = acc_start;
            x_nxt   = xs_q;
            upd     = 1'b1;
        end else if (advance && !last) begin
            acc_nxt = acc + b_ext;
            x_nxt   = x_out + X_W'(1);
            upd     = 1'b1;
        end
        raw_y   = acc_nxt >>> FRAC_BITS;
        y_nxt   = raw_y[Y_W-1:0];
        inr_nxt = 1'b1;
        if (raw_y[ACC_W-1]) begin
            y_nxt   = '0;
            inr_nxt = 1'b0;
        end else if (raw_y > Y_MAX_ACC) begin
            y_nxt   = Y_MAX_Y;
            inr_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            a_q          <= '0;
            b_q          <= '0;
            xs_q         <= '0;
            xe_q         <= '0;
            acc          <= '0;
            x_out        <= '0;
            y_out        <= '0;
            in_range_out <= 1'b0;
            valid_out    <= 1'b0;
            done_out     <= 1'b0;
            ready_out    <= 1'b1;
        end else begin
            ready_out <= (next_state == ST_IDLE);
            // Registered from the DONE state, so the pulse trails it by a cycle.
            done_out  <= (state == ST_DONE);
            if (state == ST_IDLE && valid_in) begin
                a_q  <= a_in;
                b_q  <= b_in;
                xs_q <= x_start_in;
                xe_q <= x_end_in;
            end
            if (upd) begin
                acc          <= acc_nxt;
                x_out        <= x_nxt;
                y_out        <= y_nxt;
                in_range_out <= inr_nxt;
            end
            if (state == ST_LOAD)     valid_out <= 1'b1;
            else if (advance && last) valid_out <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_line_point_gen.sv
// tb_line_point_gen: scoreboard bench; expected points come from the line
// equation evaluated with plain integer arithmetic per column.
`default_nettype none

module tb_line_point_gen;
    import line_pkg::*;

    localparam int FB = 10;
    localparam int YM = 767;

    logic                  clk_in = 1'b0;
    logic                  rst_in = 1'b1;
    logic signed [A_W-1:0] a_in = '0;
    logic signed [B_W-1:0] b_in = '0;
    logic        [X_W-1:0] x_start_in = '0, x_end_in = '0;
    logic                  valid_in = 1'b0, ready_in = 1'b1;
    logic                  ready_out, in_range_out, valid_out, done_out;
    logic        [X_W-1:0] x_out;
    logic        [Y_W-1:0] y_out;

    line_point_gen #(.FRAC_BITS(FB), .Y_MAX(YM)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .a_in(a_in), .b_in(b_in),
        .x_start_in(x_start_in), .x_end_in(x_end_in), .valid_in(valid_in),
        .ready_out(ready_out), .x_out(x_out), .y_out(y_out),
        .in_range_out(in_range_out), .valid_out(valid_out),
        .ready_in(ready_in), .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { int x; int y; int inr; } pt_t;
    pt_t expq[$];
    int  errors = 0, checks = 0, done_cnt = 0;
    int  ready_pct = 100, stall_x = -1, stall_left = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // y = floor((a*2^FB + b*x) / 2^FB), then clamped to 0..YM.
    function automatic pt_t model(input longint a, input longint b, input longint x);
        pt_t    p;
        longint v, d, q;
        d = longint'(1) << FB;
        v = a * d + b * x;
        q = v / d;
        if (v < 0 && (v % d) != 0) q = q - 1;
        p.x = int'(x);
        if (q < 0)       begin p.y = 0;      p.inr = 0; end
        else if (q > YM) begin p.y = YM;     p.inr = 0; end
        else             begin p.y = int'(q); p.inr = 1; end
        return p;
    endfunction

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (stall_left > 0 && valid_out && int'(x_out) == stall_x) begin
                ready_in   = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                ready_in = ($urandom_range(1, 100) <= ready_pct);
            end
        end
    end

    initial begin
        bit  held;
        pt_t prev, e;
        held = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", valid_out, 1);
                    chk("hold_x", x_out, prev.x);
                    chk("hold_y", y_out, prev.y);
                    chk("hold_inr", in_range_out, prev.inr);
                end
                if (valid_out) begin
                    prev.x = int'(x_out); prev.y = int'(y_out); prev.inr = int'(in_range_out);
                    if (ready_in) begin
                        if (expq.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_point: got x=%0d y=%0d, required none", x_out, y_out);
                        end else begin
                            e = expq.pop_front();
                            chk("pt_x", x_out, e.x);
                            chk("pt_y", y_out, e.y);
                            chk("pt_inr", in_range_out, e.inr);
                        end
                    end
                    held = !ready_in;
                end else begin
                    held = 1'b0;
                end
                if (done_out) done_cnt++;
            end
        end
    end

    task automatic run_line(input int a, input int b, input int xs, input int xe,
                            input int pct, input bit noise);
        int base, n;
        ready_pct = pct;
        if (xs <= xe) for (int x = xs; x <= xe; x++) expq.push_back(model(a, b, x));
        n = 0;
        while (!ready_out && n < 100) begin @(negedge clk_in); #1; n++; end
        chk("ready_before_req", ready_out, 1);
        base = done_cnt;
        @(posedge clk_in); #1;
        a_in = A_W'(a); b_in = B_W'(b);
        x_start_in = X_W'(xs); x_end_in = X_W'(xe);
        valid_in = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        @(negedge clk_in); #1;
        chk("busy_ready", ready_out, 0);
        chk("c1_valid", valid_out, 0);
        chk("c1_done", done_out, 0);
        @(negedge clk_in); #1;
        if (xs <= xe) begin
            chk("c2_valid", valid_out, 1);
        end else begin
            chk("empty_valid", valid_out, 0);
            chk("empty_done", done_out, 1);
        end
        for (int i = 0; i < 3000 && done_cnt == base; i++) begin
            if (noise) begin
                a_in = A_W'($urandom); x_start_in = X_W'($urandom); x_end_in = X_W'($urandom);
                valid_in = $urandom_range(0, 1);
            end
            @(negedge clk_in); #1;
        end
        valid_in = 1'b0;
        chk("done_seen", done_cnt - base, 1);
        chk("points_left", expq.size(), 0);
        @(negedge clk_in); #1;
        chk("done_pulse_end", done_out, 0);
        chk("ready_after", ready_out, 1);
        expq.delete();
    endtask

    initial begin
        int base, n, xs, xe;
        #2 rst_in = 1'b0;
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_inr", in_range_out, 0);
        repeat (2) @(negedge clk_in);
        #1 rst_in = 1'b1;
        chk("rst_ready", ready_out, 1);

        run_line(100, 0, 0, 3, 100, 1'b0);
        run_line(0, 512, 0, 4, 100, 1'b0);
        run_line(5, -1024, 0, 7, 100, 1'b0);
        stall_x = 11; stall_left = 3;
        run_line(0, 1024, 10, 12, 100, 1'b0);
        stall_x = -1;
        run_line(0, 0, 20, 5, 100, 1'b0);
        run_line(300, 700, 7, 7, 100, 1'b0);
        run_line(2, 3, 2040, 2047, 60, 1'b0);

        // Reset in the middle of a line.
        ready_pct = 100;
        for (int x = 0; x <= 9; x++) expq.push_back(model(0, 1024, x));
        @(posedge clk_in); #1;
        a_in = '0; b_in = B_W'(1024); x_start_in = '0; x_end_in = X_W'(9); valid_in = 1'b1;
        @(posedge clk_in); #1 valid_in = 1'b0;
        n = 0;
        while (!(valid_out && x_out == X_W'(3)) && n < 50) begin @(negedge clk_in); #1; n++; end
        chk("reached_x3", x_out, 3);
        base = done_cnt;
        #1 rst_in = 1'b0;
        #1;
        chk("midrst_valid", valid_out, 0);
        chk("midrst_done", done_out, 0);
        expq.delete();
        repeat (2) @(negedge clk_in);
        #1 rst_in = 1'b1;
        chk("midrst_ready", ready_out, 1);
        repeat (5) @(negedge clk_in);
        #1 chk("no_done_after_rst", done_cnt - base, 0);
        run_line(0, 1024, 0, 9, 100, 1'b0);

        for (int t = 0; t < 30; t++) begin
            xs = $urandom_range(0, 2047);
            if ($urandom_range(0, 9) == 0 && xs > 0) xe = $urandom_range(0, xs - 1);
            else begin
                xe = xs + $urandom_range(0, 15);
                if (xe > 2047) xe = 2047;
            end
            run_line($urandom_range(0, 1100) - 200, $urandom_range(0, 4000) - 2000,
                     xs, xe, $urandom_range(40, 100), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/line_point_gen.md
LINE_POINT_GEN -- requirements
Module: line_point_gen

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 10; fractional bits of slope coefficient.
REQ-002 SHALL have parameter Y_MAX, default 767; largest drawable row.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port a_in, input, signed 18, intercept (y at x=0, integer rows).
REQ-006 SHALL have port b_in, input, signed 25, slope scaled by 2^FRAC_BITS.
REQ-007 SHALL have port x_start_in, input, 11, first column.
REQ-008 SHALL have port x_end_in, input, 11, last column, inclusive.
REQ-009 SHALL have port valid_in, input, 1, coefficient/range request.
REQ-010 SHALL have port ready_out, output, 1, high only in IDLE.
REQ-011 SHALL have port x_out, output, 11, current column.
REQ-012 SHALL have port y_out, output, 10, row, clamped to 0..Y_MAX.
REQ-013 SHALL have port in_range_out, output, 1, low when y_out was clamped.
REQ-014 SHALL have port valid_out, output, 1, point valid.
REQ-015 SHALL have port ready_in, input, 1, downstream accepts the point.
REQ-016 SHALL have port done_out, output, 1, one-cycle end-of-line pulse.

Function
REQ-017 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-018 IDLE: on valid_in high, SHALL latch a_in, b_in, x_start_in, x_end_in and go to LOAD; if x_start_in > x_end_in, SHALL go directly to DONE, emitting no points.
REQ-019 LOAD, one cycle: SHALL set a 40-bit signed accumulator to (a << FRAC_BITS) + b*x_start and x to x_start, then go to RUN.
REQ-020 RUN: SHALL hold valid_out high. Raw y SHALL be the accumulator arithmetic-shifted right by FRAC_BITS, i.e. floor.
REQ-021 Clamping: raw y < 0 SHALL give y_out=0. Raw y > Y_MAX SHALL give y_out=Y_MAX. In both cases in_range_out SHALL be 0; otherwise in_range_out SHALL be 1.
REQ-022 While valid_out && !ready_in, x_out, y_out and in_range_out SHALL stay stable.
REQ-023 On valid_out && ready_in with x == x_end: SHALL go to DONE.
REQ-024 On valid_out && ready_in otherwise: x SHALL increment by 1 and the accumulator SHALL add sign-extended b, with the next point valid in the following cycle.
REQ-025 Throughput SHALL be one point per cycle under constant ready_in.
REQ-026 DONE: done_out SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-027 valid_in SHALL be ignored outside IDLE.
REQ-028 x_start == x_end SHALL emit exactly one point.
REQ-029 x_end = 2047 SHALL terminate without x wrap-around.
REQ-030 Latency from valid_in accepted to first valid_out SHALL be 2 cycles.
REQ-031 Outputs SHALL be registered; x_out/y_out SHALL be don't-care while valid_out is 0.

Reset
REQ-032 rst_in low SHALL immediately force state=IDLE, valid_out=0, done_out=0, x_out=0, y_out=0, in_range_out=0, and accumulator=0; ready_out SHALL be 1 after release.
REQ-033 Reset mid-RUN SHALL abandon the line with no done_out pulse.

Structure
REQ-034 Package line_pkg SHALL hold FRAC_BITS default, X_W=11, Y_W=10, ACC_W=40, Y_MAX, and the state enum; both the regression block and this block SHALL import it.
REQ-035 Submodule: none; the single start multiply SHALL be inline.

Verification
REQ-036 a=100, b=0, x 0..3, ready_in=1 -> four points with y=100, in_range=1, then done_out one cycle.
REQ-037 a=0, b=512, x 0..4 -> y = 0,0,1,1,2 on consecutive cycles.
REQ-038 a=5, b=-1024, x 0..7 -> y = 5,4,3,2,1,0,0,0 with in_range=0 only at x=6,7.
REQ-039 a=0, b=1024, x 10..12, ready_in low 3 cycles at x=11 -> x=11/y=11 held stable, then x=12/y=12 and done_out.
REQ-040 x_start=20, x_end=5 -> no valid_out, done_out 2 cycles after request, ready_out high afterward.
REQ-041 rst_in low during RUN at x=3 of 0..9 -> valid_out=0 immediately, no done_out; a fresh request then runs normally.
